axi4_burst_read_master: RTL and testbench
=========================================

// Module: axi4_burst_read_master
// PURPOSE
//  Parametrised AXI4 read master: takes one read request (address + beat count), issues one or more
//  INCR AR bursts, and streams returned R beats to a local valid/ready consumer. Splits at
//  MAX_BURST_LEN and 4KB boundaries, checks RID/RLAST/RRESP, reports per-request completion + error.
//  Successor of the single-beat read master; sits between fetch/DMA logic and the AXI interconnect.
// PARAMETERS
//  AXI_ID_WIDTH     1    ARID/RID width; ARID driven constant 0
//  AXI_ADDR_WIDTH   32   address width
//  AXI_DATA_WIDTH   64   data width, power of 2, >=8
//  AXI_RUSER_WIDTH  1    RUSER width (input, ignored)
//  MAX_BURST_LEN    16   max beats per AR burst, 1..256
//  REQ_LEN_WIDTH    8    width of req_len (beats-1); max request = 2^REQ_LEN_WIDTH beats
// PORTS
//  clk           in   1     clock
//  reset         in   1     synchronous active-high reset
//  req_valid     in   1     request valid
//  req_ready     out  1     request accepted when valid&ready
//  req_addr      in   AW    start byte address; low log2(DW/8) bits ignored (forced 0)
//  req_len       in   RLW   beats-1
//  rsp_valid     out  1     read beat valid
//  rsp_ready     in   1     consumer ready
//  rsp_data      out  DW    beat data (= axi_rdata)
//  rsp_last      out  1     final beat of whole request
//  done          out  1     1-cycle pulse after final beat accepted
//  done_err      out  1     valid with done: any error during request
//  axi_arid/araddr/arlen/arsize/arburst/arcache/arprot/arqos/arregion  out  AXI4 AR fields
//  axi_arvalid   out  1  /  axi_arready  in  1
//  axi_rid/rdata/rresp/rlast/ruser/rvalid  in  AXI4 R fields  /  axi_rready  out  1
// BEHAVIOUR
//  Reset: FSM=IDLE; req_ready=1; axi_arvalid=0, axi_rready=0, rsp_valid=0, done=0, done_err=0,
//   araddr/arlen=0. Reset mid-operation abandons request at once; outstanding R beats not tracked.
//  Constants: arid=0, arburst=2'b01, arsize=$clog2(DW/8), arcache=0, arprot=0, arqos=0, arregion=0.
//  FSM IDLE -> ADDR -> DATA -> (ADDR | IDLE).
//  IDLE: req_ready=1. On req_valid: latch aligned addr, remaining=req_len+1, err=0 -> ADDR.
//  ADDR: axi_arvalid=1, stable until axi_arready. seg = min(remaining, MAX_BURST_LEN,
//   (4096 - addr[11:0])/(DW/8)); arlen=seg-1. On handshake -> DATA, beat counter=seg-1.
//   AR issued the cycle after acceptance (1-cycle latency); no AR while in DATA (one burst in flight).
//  DATA: combinational pass-through: rsp_valid=axi_rvalid, axi_rready=rsp_ready, rsp_data=axi_rdata.
//   Beat transfers on axi_rvalid&rsp_ready; counter decrements. Segment's final beat = counter==0.
//   rsp_last=1 only on final beat of final segment.
//  Segment end: addr+=seg*(DW/8), remaining-=seg; remaining>0 -> ADDR, else -> IDLE.
//  Completion: done=1 (and done_err=err) in cycle after final beat; req_ready=1 same cycle.
//  Errors (sticky per request, never stall stream): rresp[1]==1 (SLVERR/DECERR); axi_rlast != final-beat
//   flag; axi_rid != 0. Beat count is own counter; RLAST never used to end a segment.
//  Outside DATA axi_rready=0, rsp_valid=0. req_len max -> 2^RLW beats, no overflow (counters RLW+1 bits).
//  A segment never crosses a 4KB boundary; address wrap at 2^AW unchecked.
// TESTING
//  DW=64,MBL=16: req 0x1000 len0 -> AR 0x1000 len0 size3; 1 beat, rsp_last=1; done pulse, done_err=0.
//  MBL=8: req 0x1000 len15 -> AR 0x1000 len7, then AR 0x1040 len7; 16 beats; rsp_last on 16th only.
//  req 0x0FF0 len3 -> AR 0x0FF0 len1, AR 0x1000 len1; 4 beats in order; done_err=0.
//  4-beat req, rresp=2'b10 on beat 2 -> all 4 beats delivered, done_err=1; rlast on beat 3 -> done_err=1.
//  rsp_ready=0 for 5 cycles mid-burst -> axi_rready=0, no beat lost/duplicated; data order intact.
//  reset asserted mid-DATA -> next cycle arvalid=0, rready=0, req_ready=1; new req proceeds normally.

Source files
------------

// File: rtl/axi4_burst_read_master.sv
// AXI4 burst read master: one local request becomes one or more INCR bursts,
// split at MAX_BURST_LEN and 4KB, with returned beats streamed to the consumer.
module axi4_burst_read_master #(
  parameter int AXI_ID_WIDTH    = 1,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_RUSER_WIDTH = 1,
  parameter int MAX_BURST_LEN   = 16,
  parameter int REQ_LEN_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]  req_addr,
  input  logic [REQ_LEN_WIDTH-1:0]   req_len,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]  rsp_data,
  output logic                       rsp_last,
  output logic                       done,
  output logic                       done_err,
  output logic [AXI_ID_WIDTH-1:0]    axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]  axi_araddr,
  output logic [7:0]                 axi_arlen,
  output logic [2:0]                 axi_arsize,
  output logic [1:0]                 axi_arburst,
  output logic [3:0]                 axi_arcache,
  output logic [2:0]                 axi_arprot,
  output logic [3:0]                 axi_arqos,
  output logic [3:0]                 axi_arregion,
  output logic                       axi_arvalid,
  input  logic                       axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]    axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]  axi_rdata,
  input  logic [1:0]                 axi_rresp,
  input  logic                       axi_rlast,
  input  logic [AXI_RUSER_WIDTH-1:0] axi_ruser,
  input  logic                       axi_rvalid,
  output logic                       axi_rready
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int RW    = REQ_LEN_WIDTH + 1;
  localparam int CW    = (RW > 13) ? RW : 13;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]             rem_q;
  logic [8:0]                seg_q, cnt_q;
  logic                      err_q, done_q, done_err_q;

  logic [12:0]   bnd_bytes;
  logic [CW-1:0] rem_w, mbl_w, bnd_w, seg_w;
  logic          beat, seg_end, final_seg, req_done, beat_err;
  logic          unused_ok;

  // Beats left before the next 4KB page, in data-width units
  assign bnd_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
  assign bnd_w     = CW'(bnd_bytes >> LSB);
  assign rem_w     = CW'(rem_q);
  assign mbl_w     = CW'(MAX_BURST_LEN);

  always_comb begin
    seg_w = rem_w;
    if (mbl_w < seg_w) seg_w = mbl_w;
    if (bnd_w < seg_w) seg_w = bnd_w;
  end

  assign beat      = (state_q == DATA) && axi_rvalid && rsp_ready;
  assign seg_end   = beat && (cnt_q == '0);
  assign final_seg = (rem_q == RW'(seg_q));
  assign req_done  = seg_end && final_seg;
  assign beat_err  = axi_rresp[1]
                   | (axi_rlast != (cnt_q == '0))
                   | (axi_rid != '0);

  assign axi_arid     = '0;
  assign axi_araddr   = addr_q;
  assign axi_arlen    = (state_q == ADDR) ? 8'(seg_w - CW'(1)) : 8'd0;
  assign axi_arsize   = 3'(LSB);
  assign axi_arburst  = 2'b01;
  assign axi_arcache  = 4'b0;
  assign axi_arprot   = 3'b0;
  assign axi_arqos    = 4'b0;
  assign axi_arregion = 4'b0;
  assign rsp_data     = axi_rdata;
  assign done         = done_q;
  assign done_err     = done_err_q;
  assign unused_ok    = ^{axi_ruser, axi_rresp[0]};

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    rsp_valid   = 1'b0;
    rsp_last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ADDR;
      end
      ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_d = DATA;
      end
      DATA: begin
        rsp_valid  = axi_rvalid;
        axi_rready = rsp_ready;
        rsp_last   = (cnt_q == '0) && final_seg;
        if (seg_end) state_d = final_seg ? IDLE : ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      seg_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= req_done;
      done_err_q <= req_done & (err_q | beat_err);
      if (state_q == IDLE && req_valid) begin
        addr_q <= req_addr & ~AXI_ADDR_WIDTH'(BYTES - 1);
        rem_q  <= {1'b0, req_len} + RW'(1);
        err_q  <= 1'b0;
      end
      if (state_q == ADDR && axi_arready) begin
        seg_q <= 9'(seg_w);
        cnt_q <= 9'(seg_w) - 9'd1;
      end
      if (beat) begin
        err_q <= err_q | beat_err;
        cnt_q <= cnt_q - 9'd1;
        if (seg_end) begin
          addr_q <= addr_q + (AXI_ADDR_WIDTH'(seg_q) << LSB);
          rem_q  <= rem_q - RW'(seg_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_read_master.sv
// Bench for axi4_burst_read_master: reactive AXI slave model plus
// scoreboard of expected AR bursts, beats and completion status.
module tb_axi4_burst_read_master;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int MBL = 8;
  localparam int RLW = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req_valid, req_ready;
  logic [AW-1:0]  req_addr;
  logic [RLW-1:0] req_len;
  logic           rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0]  rsp_data;
  logic           done, done_err;
  logic [0:0]     axi_arid, axi_rid;
  logic [AW-1:0]  axi_araddr;
  logic [7:0]     axi_arlen;
  logic [2:0]     axi_arsize, axi_arprot;
  logic [1:0]     axi_arburst, axi_rresp;
  logic [3:0]     axi_arcache, axi_arqos, axi_arregion;
  logic           axi_arvalid, axi_arready;
  logic [DW-1:0]  axi_rdata;
  logic           axi_rlast, axi_rvalid, axi_rready;
  logic [0:0]     axi_ruser;

  always #5 clk = ~clk;

  axi4_burst_read_master #(
    .AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_RUSER_WIDTH(1), .MAX_BURST_LEN(MBL), .REQ_LEN_WIDTH(RLW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done), .done_err(done_err),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arqos(axi_arqos), .axi_arregion(axi_arregion),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_ruser(axi_ruser),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_ar[$];
  logic [64:0] exp_beat[$];
  logic        exp_err_q[$];

  bit          ar_fire, r_fire, rst_seen, done_seen;
  logic [39:0] ar_cap;
  int          done_cnt = 0;
  int          beats_rx = 0;
  int          inj_resp = -1;
  int          inj_last = -1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Reference split: page-limited, MBL-limited INCR segments
  task automatic push_exp(input logic [31:0] a, input int len,
                          input logic err);
    logic [31:0] cur;
    int rem, seg, bnd;
    cur = a & ~32'h7;
    rem = len + 1;
    while (rem > 0) begin
      seg = (rem > MBL) ? MBL : rem;
      bnd = (4096 - int'(cur[11:0])) / 8;
      if (seg > bnd) seg = bnd;
      exp_ar.push_back({cur, 8'(seg - 1)});
      for (int i = 0; i < seg; i++)
        exp_beat.push_back({(rem == seg) && (i == seg - 1),
                            data_of(cur + 32'(8 * i))});
      cur = cur + 32'(8 * seg);
      rem = rem - seg;
    end
    exp_err_q.push_back(err);
  endtask

  // Monitor: values at negedge are what the next posedge samples
  always @(negedge clk) begin
    logic [39:0] e;
    logic [64:0] b;
    ar_fire   = axi_arvalid && axi_arready;
    r_fire    = axi_rvalid && axi_rready;
    rst_seen  = reset;
    done_seen = done;
    ar_cap    = {axi_araddr, axi_arlen};
    if (!reset) begin
      if (ar_fire) begin
        chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
        if (exp_ar.size() != 0) begin
          e = exp_ar.pop_front();
          chk("ar_addr_len", 64'({axi_araddr, axi_arlen}), 64'(e));
          chk("ar_consts",
              64'({axi_arsize, axi_arburst, axi_arid, axi_arcache,
                   axi_arprot, axi_arqos, axi_arregion}),
              64'({3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0}));
        end
      end
      if (rsp_valid && rsp_ready) begin
        beats_rx++;
        chk("beat_expected", 64'(exp_beat.size() != 0), 64'd1);
        if (exp_beat.size() != 0) begin
          b = exp_beat.pop_front();
          chk("beat_data", rsp_data, b[63:0]);
          chk("beat_last", 64'(rsp_last), 64'(b[64]));
          chk("beat_rready", 64'(axi_rready), 64'd1);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_expected", 64'(exp_err_q.size() != 0), 64'd1);
        if (exp_err_q.size() != 0)
          chk("done_err", 64'(done_err), 64'(exp_err_q.pop_front()));
        chk("done_req_ready", 64'(req_ready), 64'd1);
      end
    end
  end

  // AXI slave: accepts AR, returns beats in order with random gaps
  logic [39:0] bq[$];
  logic [31:0] cur_addr;
  int          cur_len, beat_i, req_beat;
  bit          active;

  initial begin
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rresp   = 2'b00;
    axi_rlast   = 1'b0;
    axi_rid     = '0;
    axi_ruser   = '0;
    active      = 1'b0;
    cur_addr    = '0;
    cur_len     = 0;
    beat_i      = 0;
    req_beat    = 0;
  end

  always @(posedge clk) begin
    #1;
    if (rst_seen) begin
      bq.delete();
      active      = 1'b0;
      axi_rvalid  = 1'b0;
      axi_arready = 1'b0;
      req_beat    = 0;
      beat_i      = 0;
    end else begin
      if (r_fire) begin
        req_beat++;
        if (beat_i == cur_len) active = 1'b0;
        else beat_i++;
      end
      if (done_seen) req_beat = 0;
      if (ar_fire) bq.push_back(ar_cap);
      if (!active && bq.size() != 0) begin
        {cur_addr, cur_len} = {bq[0][39:8], 24'd0, bq[0][7:0]};
        void'(bq.pop_front());
        beat_i = 0;
        active = 1'b1;
      end
      if (!(axi_rvalid && !r_fire))
        axi_rvalid = active && ($urandom_range(0, 3) != 0);
      axi_rdata   = data_of(cur_addr + 32'(8 * beat_i));
      axi_rlast   = (beat_i == cur_len) ^ (req_beat == inj_last);
      axi_rresp   = (req_beat == inj_resp) ? 2'b10 : 2'b00;
      axi_arready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] a, input int len,
                      input logic err);
    bit acc;
    acc = 1'b0;
    push_exp(a, len, err);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = RLW'(len);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("req_accepted", 64'(acc), 64'd1);
    @(negedge clk);
    chk("ar_latency", 64'(axi_arvalid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget && beats_rx < target; i++) begin
      @(posedge clk); #1;
    end
    chk("beats_seen", 64'(beats_rx >= target), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    rsp_ready = 1'b1;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
    chk("rst_rready", 64'(axi_rready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_done", 64'({done, done_err}), 64'd0);
    chk("rst_ar_fields", 64'({axi_araddr, axi_arlen}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    send(32'h1000, 0, 1'b0);
    wait_done(1, 200);
    send(32'h1000, 15, 1'b0);
    wait_done(2, 400);
    send(32'h0FF0, 3, 1'b0);
    wait_done(3, 200);

    inj_resp = 1;
    send(32'h3000, 3, 1'b1);
    wait_done(4, 200);
    inj_resp = -1;

    inj_last = 2;
    send(32'h3100, 3, 1'b1);
    wait_done(5, 200);
    inj_last = -1;

    send(32'h2000, 15, 1'b0);
    wait_beats(beats_rx + 3, 200);
    rsp_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rready", 64'(axi_rready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_done(6, 400);

    send(32'h8005, 255, 1'b0);
    wait_done(7, 3000);
    send(32'h1F80, 20, 1'b0);
    wait_done(8, 600);

    send(32'h4000, 15, 1'b0);
    wait_beats(beats_rx + 4, 200);
    reset = 1'b1;
    exp_ar.delete();
    exp_beat.delete();
    exp_err_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_arvalid", 64'(axi_arvalid), 64'd0);
    chk("mid_rst_rready", 64'(axi_rready), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    send(32'h5000, 7, 1'b0);
    wait_done(done_cnt + 1, 300);

    repeat (5) @(posedge clk);
    #1;
    chk("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
    chk("beat_queue_empty", 64'(exp_beat.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_err_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
